// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-port arbiter for the shared single-port data memory
// Optional feature: define DRAM_ARB_RR_EN to turn the both-requesting tie-break into round-robin.
// The default build (DRAM_ARB_RR_EN undefined) uses fixed port-0 priority and has no rr_last state.
module dram_arbiter #(
  parameter int AW       = 19,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 15,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  input  logic [DW-1:0] m_rdata
);

  localparam logic [CW-1:0] WAIT_CAP = CW'(MAX_WAIT);

  logic [CW-1:0] wait0_q, wait0_d;
  logic [CW-1:0] wait1_q, wait1_d;
  logic          lock_own_q, lock_own_d;
  logic          p0_rvalid_q, p0_rvalid_d;
  logic          p1_rvalid_q, p1_rvalid_d;
  logic          gnt0, gnt1;
  logic          starve0, starve1;
`ifdef DRAM_ARB_RR_EN
  logic          rr_last_q, rr_last_d;
`endif

  // Grant decision: starvation, then port-1 lock, then single requester, then tie-break
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    starve0 = p0_req && (wait0_q == WAIT_CAP);
    starve1 = p1_req && (wait1_q == WAIT_CAP);
    if (rst) begin
      // Reset holds the memory idle so nothing is consumed during reset.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (starve0) begin
      gnt0 = 1'b1;
    end else if (starve1) begin
      gnt1 = 1'b1;
    end else if (lock_own_q && p1_req) begin
      gnt1 = 1'b1;
    end else if (p0_req && !p1_req) begin
      gnt0 = 1'b1;
    end else if (p1_req && !p0_req) begin
      gnt1 = 1'b1;
    end else if (p0_req && p1_req) begin
`ifdef DRAM_ARB_RR_EN
      // The port that was not granted most recently wins the tie.
      gnt0 = rr_last_q;
      gnt1 = !rr_last_q;
`else
      gnt0 = 1'b1;
`endif
    end
  end

  // Memory steering driven only by the grant; idle performs a read of address 0
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_we    = 1'b0;
    if (gnt0) begin
      m_addr  = p0_addr;
      m_wdata = p0_wdata;
      m_we    = p0_we;
    end else if (gnt1) begin
      m_addr  = p1_addr;
      m_wdata = p1_wdata;
      m_we    = p1_we;
    end
  end

  // Next-state: saturating wait counters, lock ownership, read-valid pipeline
  always_comb begin
    wait0_d = '0;
    wait1_d = '0;
    if (p0_req && !gnt0) begin
      wait0_d = (wait0_q == WAIT_CAP) ? wait0_q : wait0_q + 1'b1;
    end
    if (p1_req && !gnt1) begin
      wait1_d = (wait1_q == WAIT_CAP) ? wait1_q : wait1_q + 1'b1;
    end
    // Ownership survives only while port 1 is granted and keeps asking for the lock.
    lock_own_d  = gnt1 && p1_lock;
    p0_rvalid_d = gnt0 && !p0_we;
    p1_rvalid_d = gnt1 && !p1_we;
  end

`ifdef DRAM_ARB_RR_EN
  // Round-robin history follows every grant regardless of which rule issued it
  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt0) begin
      rr_last_d = 1'b0;
    end else if (gnt1) begin
      rr_last_d = 1'b1;
    end
  end

  // Round-robin history register; port 0 wins the first tie after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wait0_q     <= '0;
      wait1_q     <= '0;
      lock_own_q  <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      wait0_q     <= wait0_d;
      wait1_q     <= wait1_d;
      lock_own_q  <= lock_own_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign rdata     = m_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - table-driven and sequence checks for dram_arbiter
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we;
  logic [18:0] p0_addr;
  logic [7:0]  p0_wdata;
  logic        p0_gnt, p0_rvalid;
  logic        p1_req, p1_we, p1_lock;
  logic [18:0] p1_addr;
  logic [7:0]  p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [7:0]  rdata;
  logic [18:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_we;
  logic [7:0]  m_rdata;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:(1<<19)-1];

  always #5 clk = ~clk;

  // Single-port memory with a registered read
  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
    m_rdata <= mem[m_addr];
  end

  dram_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        p0_req, p0_we;
    logic [18:0] p0_addr;
    logic [7:0]  p0_wdata;
    logic        p1_req, p1_we, p1_lock;
    logic [18:0] p1_addr;
    logic [7:0]  p1_wdata;
    logic        e_p0_gnt, e_p1_gnt, e_m_we;
    logic [18:0] e_m_addr;
    logic [7:0]  e_m_wdata;
    logic        e_p0_rvalid, e_p1_rvalid, chk_rdata;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  task automatic check_gnt(input string tag, input int c, input logic e0, input logic e1);
    @(negedge clk);
    check($sformatf("%s c%0d p0_gnt", tag, c), 32'(p0_gnt), 32'(e0));
    check($sformatf("%s c%0d p1_gnt", tag, c), 32'(p1_gnt), 32'(e1));
  endtask

  initial begin
    vecs[0]  = '{default:0, p0_req:1, p0_we:1, p0_addr:19'h00010, p0_wdata:8'hA5,
                 e_p0_gnt:1, e_m_we:1, e_m_addr:19'h00010, e_m_wdata:8'hA5};
    vecs[1]  = '{default:0, p0_req:1, p0_addr:19'h00010, e_p0_gnt:1, e_m_addr:19'h00010};
    vecs[2]  = '{default:0, p1_req:1, p1_we:1, p1_addr:19'h3FFFF, p1_wdata:8'h5A,
                 e_p1_gnt:1, e_m_we:1, e_m_addr:19'h3FFFF, e_m_wdata:8'h5A,
                 e_p0_rvalid:1, chk_rdata:1, e_rdata:8'hA5};
    vecs[3]  = '{default:0, p1_req:1, p1_addr:19'h3FFFF, e_p1_gnt:1, e_m_addr:19'h3FFFF};
    vecs[4]  = '{default:0, e_p1_rvalid:1, chk_rdata:1, e_rdata:8'h5A};
    vecs[5]  = '{default:0, p0_req:1, p0_we:1, p0_addr:19'h00100, p0_wdata:8'h11,
                 p1_req:1, p1_addr:19'h00200,
                 e_p0_gnt:1, e_m_we:1, e_m_addr:19'h00100, e_m_wdata:8'h11};
    vecs[6]  = '{default:0, p1_req:1, p1_we:1, p1_addr:19'h00200, p1_wdata:8'hC3,
                 e_p1_gnt:1, e_m_we:1, e_m_addr:19'h00200, e_m_wdata:8'hC3};
    vecs[7]  = '{default:0, p0_req:1, p0_addr:19'h00100, p1_req:1, p1_addr:19'h00200,
                 e_p0_gnt:1, e_m_addr:19'h00100};
    vecs[8]  = '{default:0, p1_req:1, p1_addr:19'h00200, e_p1_gnt:1, e_m_addr:19'h00200,
                 e_p0_rvalid:1, chk_rdata:1, e_rdata:8'h11};
    vecs[9]  = '{default:0, p0_addr:19'h7FFFF, p0_wdata:8'hFF, p0_we:1,
                 p1_req:1, p1_we:1, p1_addr:19'h00005, p1_wdata:8'h22,
                 e_p1_gnt:1, e_m_we:1, e_m_addr:19'h00005, e_m_wdata:8'h22,
                 e_p1_rvalid:1, chk_rdata:1, e_rdata:8'hC3};
    vecs[10] = '{default:0, p0_addr:19'h12345, p0_wdata:8'h99, p0_we:1,
                 p1_addr:19'h54321, p1_wdata:8'h77, p1_we:1, p1_lock:1};

    // Reset state: requests present but reset forces the idle rule
    rst = 1;
    set_idle();
    p0_req = 1; p0_we = 1; p1_req = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst p0_gnt", 32'(p0_gnt), 0);
    check("rst p1_gnt", 32'(p1_gnt), 0);
    check("rst m_we", 32'(m_we), 0);
    check("rst p0_rvalid", 32'(p0_rvalid), 0);
    check("rst p1_rvalid", 32'(p1_rvalid), 0);
    next_cycle();
    rst = 0;
    set_idle();

    // Vector table: one cycle per record
    for (int i = 0; i < 11; i++) begin
      p0_req = vecs[i].p0_req; p0_we = vecs[i].p0_we;
      p0_addr = vecs[i].p0_addr; p0_wdata = vecs[i].p0_wdata;
      p1_req = vecs[i].p1_req; p1_we = vecs[i].p1_we; p1_lock = vecs[i].p1_lock;
      p1_addr = vecs[i].p1_addr; p1_wdata = vecs[i].p1_wdata;
      @(negedge clk);
      check($sformatf("v%0d p0_gnt", i), 32'(p0_gnt), 32'(vecs[i].e_p0_gnt));
      check($sformatf("v%0d p1_gnt", i), 32'(p1_gnt), 32'(vecs[i].e_p1_gnt));
      check($sformatf("v%0d m_we", i), 32'(m_we), 32'(vecs[i].e_m_we));
      check($sformatf("v%0d m_addr", i), 32'(m_addr), 32'(vecs[i].e_m_addr));
      check($sformatf("v%0d m_wdata", i), 32'(m_wdata), 32'(vecs[i].e_m_wdata));
      check($sformatf("v%0d p0_rvalid", i), 32'(p0_rvalid), 32'(vecs[i].e_p0_rvalid));
      check($sformatf("v%0d p1_rvalid", i), 32'(p1_rvalid), 32'(vecs[i].e_p1_rvalid));
      if (vecs[i].chk_rdata) check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
      next_cycle();
    end

    // Continuous contention: starvation cap (fixed) or alternation (round-robin)
    do_reset();
    p0_req = 1; p0_addr = 19'h1; p1_req = 1; p1_addr = 19'h2;
    for (int c = 0; c < 48; c++) begin
`ifdef DRAM_ARB_RR_EN
      check_gnt("contend", c, (c % 2) == 0, (c % 2) == 1);
`else
      check_gnt("contend", c, (c % 16) != 15, (c % 16) == 15);
`endif
      next_cycle();
    end

    // Locked port-1 burst of 20 reads; port 0 joins one cycle later with a single read
    do_reset();
    begin
      int p1_done = 0;
      logic p0_done = 0;
      for (int c = 0; c < 22; c++) begin
        p1_req = (p1_done < 20); p1_lock = 1; p1_addr = 19'(p1_done);
        p0_req = (c >= 1) && !p0_done; p0_addr = 19'h00010;
        check_gnt("burst", c, c == 16, (c <= 15) || (c >= 17 && c <= 20));
        if (c == 17) begin
          check("burst p0_rvalid", 32'(p0_rvalid), 1);
          check("burst rdata", 32'(rdata), 32'hA5);
        end
        if (p1_gnt) p1_done++;
        if (p0_gnt) p0_done = 1;
        next_cycle();
      end
      check("burst p1 reads", 32'(p1_done), 20);
    end

    // Lock release by dropping p1_lock and by dropping p1_req
    do_reset();
    begin
      logic [5:0] s_p0 = 6'b110110;
      logic [5:0] s_p1 = 6'b101011;
      logic [5:0] s_lk = 6'b101001;
`ifdef DRAM_ARB_RR_EN
      logic [5:0] e_p1 = 6'b101011;
`else
      logic [5:0] e_p1 = 6'b001011;
`endif
      for (int c = 0; c < 6; c++) begin
        p0_req = s_p0[c]; p1_req = s_p1[c]; p1_lock = s_lk[c];
        check_gnt("unlock", c, !e_p1[c], e_p1[c]);
        next_cycle();
      end
    end

    // Reset mid-read with wait counter and lock built up beforehand
    do_reset();
    p0_req = 1; p1_req = 1; p1_addr = 19'h3;
    repeat (10) next_cycle();
    p0_req = 0; p1_lock = 1;
    check_gnt("prelock", 0, 0, 1);
    next_cycle();
    rst = 1; p0_req = 1; p0_we = 0; p0_addr = 19'h00010;
    check_gnt("midrst", 0, 0, 0);
    next_cycle();
    rst = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 0) begin
        check_gnt("postrst", k, 1, 0);
        check("postrst p0_rvalid", 32'(p0_rvalid), 0);
      end
`ifndef DRAM_ARB_RR_EN
      else check_gnt("postrst", k, k < 15, k >= 15);
`endif
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
